// File: rtl/accu_avg_buffer.sv
// First-word-fall-through buffer for 4-sample accumulator sums.
// Each buffered sum is presented as an average (sum / 4) and a remainder, and accepted sums are counted.
module accu_avg_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [9:0]               data_in,
   input  logic                     valid_in,
   output logic                     ready_in,
   output logic [7:0]               avg_out,
   output logic [1:0]               rem_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         result_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          push;
   logic          pop;

   // Both handshake flags come from the registered level only, so there is no pass-through when full
   assign ready_in  = (level != FULL_LEVEL);
   assign valid_out = (level != '0);
   assign push      = valid_in & ready_in;
   assign pop       = valid_out & ready_out;

   assign avg_out = mem[rp][9:2];
   assign rem_out = mem[rp][1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wp         <= '0;
         rp         <= '0;
         level      <= '0;
         result_cnt <= '0;
      end else begin
         if (push) begin
            mem[wp]    <= data_in;
            wp         <= wp + AW'(1);
            result_cnt <= result_cnt + CNT_W'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         if (push && !pop) begin
            level <= level + (AW+1)'(1);
         end else if (pop && !push) begin
            level <= level - (AW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_accu_avg_buffer.sv
// Self-checking bench for accu_avg_buffer: a directed vector table plus hand-written
// sequences for reset, simultaneous push/pop, full-with-pop, streaming and counter wrap.
module tb_accu_avg_buffer;

   logic        clk;
   logic        rst_n;
   logic [9:0]  data_in;
   logic        valid_in;
   logic        ready_in;
   logic [7:0]  avg_out;
   logic [1:0]  rem_out;
   logic        valid_out;
   logic        ready_out;
   logic [2:0]  level;
   logic [15:0] result_cnt;

   logic [9:0]  data_in4;
   logic        valid_in4;
   logic        ready_in4;
   logic [7:0]  avg_out4;
   logic [1:0]  rem_out4;
   logic        valid_out4;
   logic        ready_out4;
   logic [2:0]  level4;
   logic [3:0]  result_cnt4;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic       vi;
      logic [9:0] din;
      logic       ro;
      logic       expVo;
      logic [7:0] expAvg;
      logic [1:0] expRem;
      logic [2:0] expLevel;
      logic       expRi;
      logic [15:0] expCnt;
   } vec_t;

   vec_t vecs [9];

   accu_avg_buffer #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in), .avg_out(avg_out), .rem_out(rem_out),
      .valid_out(valid_out), .ready_out(ready_out), .level(level),
      .result_cnt(result_cnt)
   );

   accu_avg_buffer #(.DEPTH(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in4), .valid_in(valid_in4),
      .ready_in(ready_in4), .avg_out(avg_out4), .rem_out(rem_out4),
      .valid_out(valid_out4), .ready_out(ready_out4), .level(level4),
      .result_cnt(result_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive the inputs, take one rising edge, then settle so outputs are sampled clear of the edge
   task automatic applyStimulus(input logic vi, input logic [9:0] din, input logic ro);
      valid_in  = vi;
      data_in   = din;
      ready_out = ro;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus4(input logic vi, input logic [9:0] din, input logic ro);
      valid_in4  = vi;
      data_in4   = din;
      ready_out4 = ro;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      #2;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic checkHead(input string name, input logic [9:0] sum, input logic [2:0] lvl);
      checkOutput({name, " valid_out"}, 32'(valid_out), 32'd1);
      checkOutput({name, " avg_out"}, 32'(avg_out), 32'(sum / 4));
      checkOutput({name, " rem_out"}, 32'(rem_out), 32'(sum % 4));
      checkOutput({name, " level"}, 32'(level), 32'(lvl));
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b1;
      valid_in    = 1'b0;
      data_in     = '0;
      ready_out   = 1'b0;
      valid_in4   = 1'b0;
      data_in4    = '0;
      ready_out4  = 1'b0;

      // Fill with 4..20 (20 rejected when full), then drain
      vecs[0] = '{1'b1, 10'd4,  1'b0, 1'b1, 8'd1, 2'd0, 3'd1, 1'b1, 16'd1};
      vecs[1] = '{1'b1, 10'd8,  1'b0, 1'b1, 8'd1, 2'd0, 3'd2, 1'b1, 16'd2};
      vecs[2] = '{1'b1, 10'd12, 1'b0, 1'b1, 8'd1, 2'd0, 3'd3, 1'b1, 16'd3};
      vecs[3] = '{1'b1, 10'd16, 1'b0, 1'b1, 8'd1, 2'd0, 3'd4, 1'b0, 16'd4};
      vecs[4] = '{1'b1, 10'd20, 1'b0, 1'b1, 8'd1, 2'd0, 3'd4, 1'b0, 16'd4};
      vecs[5] = '{1'b0, 10'd0,  1'b1, 1'b1, 8'd2, 2'd0, 3'd3, 1'b1, 16'd4};
      vecs[6] = '{1'b0, 10'd0,  1'b1, 1'b1, 8'd3, 2'd0, 3'd2, 1'b1, 16'd4};
      vecs[7] = '{1'b0, 10'd0,  1'b1, 1'b1, 8'd4, 2'd0, 3'd1, 1'b1, 16'd4};
      vecs[8] = '{1'b0, 10'd0,  1'b1, 1'b0, 8'd0, 2'd0, 3'd0, 1'b1, 16'd4};

      doReset();
      checkOutput("reset valid_out", 32'(valid_out), 32'd0);
      checkOutput("reset ready_in", 32'(ready_in), 32'd1);
      checkOutput("reset level", 32'(level), 32'd0);
      checkOutput("reset result_cnt", 32'(result_cnt), 32'd0);
      checkOutput("reset avg_out", 32'(avg_out), 32'd0);

      // Single push of the near-maximum sum, then asynchronous reset mid-operation
      applyStimulus(1'b1, 10'd1021, 1'b0);
      checkOutput("single valid_out", 32'(valid_out), 32'd1);
      checkOutput("single avg_out", 32'(avg_out), 32'd255);
      checkOutput("single rem_out", 32'(rem_out), 32'd1);
      checkOutput("single level", 32'(level), 32'd1);
      checkOutput("single result_cnt", 32'(result_cnt), 32'd1);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset valid_out", 32'(valid_out), 32'd0);
      checkOutput("async reset avg_out", 32'(avg_out), 32'd0);
      checkOutput("async reset rem_out", 32'(rem_out), 32'd0);
      checkOutput("async reset level", 32'(level), 32'd0);
      checkOutput("async reset result_cnt", 32'(result_cnt), 32'd0);
      checkOutput("async reset ready_in", 32'(ready_in), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].vi, vecs[i].din, vecs[i].ro);
         checkOutput($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].expVo));
         if (vecs[i].expVo) begin
            checkOutput($sformatf("vec%0d avg_out", i), 32'(avg_out), 32'(vecs[i].expAvg));
            checkOutput($sformatf("vec%0d rem_out", i), 32'(rem_out), 32'(vecs[i].expRem));
         end
         checkOutput($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d ready_in", i), 32'(ready_in), 32'(vecs[i].expRi));
         checkOutput($sformatf("vec%0d result_cnt", i), 32'(result_cnt), 32'(vecs[i].expCnt));
      end

      // Simultaneous push/pop at level 1
      doReset();
      applyStimulus(1'b1, 10'd7, 1'b0);
      checkHead("head7", 10'd7, 3'd1);
      applyStimulus(1'b1, 10'd9, 1'b1);
      checkHead("pushpop9", 10'd9, 3'd1);

      // Full plus pop: input refused while full, accepted next cycle
      applyStimulus(1'b1, 10'd10, 1'b0);
      applyStimulus(1'b1, 10'd11, 1'b0);
      applyStimulus(1'b1, 10'd12, 1'b0);
      checkOutput("full level", 32'(level), 32'd4);
      checkOutput("full ready_in", 32'(ready_in), 32'd0);
      applyStimulus(1'b1, 10'd40, 1'b1);
      checkHead("fullpop", 10'd10, 3'd3);
      checkOutput("fullpop result_cnt", 32'(result_cnt), 32'd5);
      checkOutput("fullpop ready_in", 32'(ready_in), 32'd1);
      applyStimulus(1'b1, 10'd40, 1'b0);
      checkOutput("refill level", 32'(level), 32'd4);
      checkOutput("refill result_cnt", 32'(result_cnt), 32'd6);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkHead("drain11", 10'd11, 3'd3);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkHead("drain12", 10'd12, 3'd2);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkHead("drain40", 10'd40, 3'd1);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput("drained valid_out", 32'(valid_out), 32'd0);

      // Back-to-back streaming across pointer wrap
      doReset();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 10'(100 + k), 1'b1);
         checkHead($sformatf("stream%0d", k), 10'(100 + k), 3'd1);
      end
      checkOutput("stream result_cnt", 32'(result_cnt), 32'd10);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput("stream end valid_out", 32'(valid_out), 32'd0);
      checkOutput("stream end level", 32'(level), 32'd0);

      // Counter wrap on the narrow-counter instance, then pop while empty
      doReset();
      for (int k = 0; k < 17; k++) begin
         applyStimulus4(1'b1, 10'(k), 1'b1);
      end
      checkOutput("wrap result_cnt", 32'(result_cnt4), 32'd1);
      applyStimulus4(1'b0, 10'd0, 1'b1);
      applyStimulus4(1'b0, 10'd0, 1'b1);
      checkOutput("empty pop level", 32'(level4), 32'd0);
      checkOutput("empty pop valid_out", 32'(valid_out4), 32'd0);
      applyStimulus4(1'b1, 10'd13, 1'b0);
      checkOutput("after empty pop avg_out", 32'(avg_out4), 32'd3);
      checkOutput("after empty pop rem_out", 32'(rem_out4), 32'd1);
      checkOutput("after empty pop level", 32'(level4), 32'd1);
      checkOutput("after empty pop result_cnt", 32'(result_cnt4), 32'd2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
